// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-ported word RAM.
// One access in flight at a time; round-robin on ties, fixed latency, address and timeout errors.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_en,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned WW    = 8;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_e;

    typedef struct packed {
        logic          port_d;
        logic          we;
        logic [WW-1:0] word;
        logic [DW-1:0] wdata;
    } req_t;

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    logic             last_d_q, last_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             gnt_i_c, gnt_d_c;
    logic [AW-1:0]    cap_addr_c;
    logic             rsp_valid_c, rsp_err_c;
    logic [DW-1:0]    rsp_data_c;
    logic             ram_en_c, ram_we_c;
    logic [WW-1:0]    ram_addr_c;
    logic [DW-1:0]    ram_wdata_c;

    // Word-aligned and inside the 1 KiB RAM window.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a[1:0] == 2'b00) && (a[AW-1:10] == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        gnt_i_c     = 1'b0;
        gnt_d_c     = 1'b0;
        cap_addr_c  = '0;
        rsp_valid_c = 1'b0;
        rsp_err_c   = 1'b0;
        rsp_data_c  = '0;
        ram_en_c    = 1'b0;
        ram_we_c    = 1'b0;
        ram_addr_c  = '0;
        ram_wdata_c = '0;

        unique case (state_q)
            IDLE: begin
                // Data wins unless it was the last port served and fetch is also waiting.
                gnt_d_c = d_req && (!i_req || !last_d_q);
                gnt_i_c = i_req && !gnt_d_c;
                if (gnt_i_c || gnt_d_c) begin
                    cap_addr_c   = gnt_d_c ? d_addr : i_addr;
                    last_d_d     = gnt_d_c;
                    req_d.port_d = gnt_d_c;
                    req_d.we     = gnt_d_c && d_we;
                    req_d.word   = cap_addr_c[9:2];
                    req_d.wdata  = (gnt_d_c && d_we) ? d_wdata : '0;
                    cnt_d        = '0;
                    state_d      = addr_ok(cap_addr_c) ? ISSUE : ERR;
                end
            end
            ISSUE: begin
                ram_en_c    = 1'b1;
                ram_we_c    = req_q.we;
                ram_addr_c  = req_q.word;
                ram_wdata_c = req_q.wdata;
                state_d     = WAIT;
            end
            WAIT: begin
                if (ram_ack) begin
                    rsp_valid_c = 1'b1;
                    rsp_data_c  = req_q.we ? '0 : ram_rdata;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                rsp_valid_c = 1'b1;
                rsp_err_c   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Steer the response to the owning port; everything is held at zero while rst is high.
    always_comb begin
        i_gnt     = !rst && gnt_i_c;
        d_gnt     = !rst && gnt_d_c;
        i_rvalid  = !rst && rsp_valid_c && !req_q.port_d;
        d_rvalid  = !rst && rsp_valid_c && req_q.port_d;
        i_err     = !rst && rsp_err_c && !req_q.port_d;
        d_err     = !rst && rsp_err_c && req_q.port_d;
        i_rdata   = (!rst && !req_q.port_d) ? rsp_data_c : '0;
        d_rdata   = (!rst && req_q.port_d) ? rsp_data_c : '0;
        ram_en    = !rst && ram_en_c;
        ram_we    = !rst && ram_we_c;
        ram_addr  = rst ? '0 : ram_addr_c;
        ram_wdata = rst ? '0 : ram_wdata_c;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: a RAM model plus a cycle-level
// transaction model that predicts grants, RAM strobes and responses.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_en, ram_we, ram_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          noack;
        int          gap;
    } txn_t;

    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    int   rst_cnt  = 0;
    bit   init_mem = 1'b0;
    bit   noise_en = 1'b0;
    bit   noack_active = 1'b0;
    int   force_a  = -1;
    int   force_b  = -1;

    logic [31:0] ram_mem   [256];
    logic [31:0] model_mem [256];

    txn_t iq[$], dq[$];
    int   i_wait = 0, d_wait = 0;

    // Reference model state, in absolute cycle numbers.
    bit          last_d = 1'b0;
    int          free_cyc = 0, resp_cyc = 0, iss_cyc = 0;
    bit          resp_pend = 1'b0, rp_d = 1'b0, rerr = 1'b0, iss_ok = 1'b0;
    logic [31:0] rdata_exp = '0, iss_wdata = '0;
    logic [7:0]  iss_word = '0;
    bit          iss_we = 1'b0;

    // Observations from the DUT used by the directed checks.
    int          gnt_cyc [2];
    int          rsp_cyc [2];
    bit          rsp_err [2];
    logic [31:0] rsp_data [2];
    int          ram_en_cnt = 0, rsp_cnt = 0, d_gnt_cnt = 0;
    logic [7:0]  last_ram_addr = '0;
    bit          glog_port[$];
    int          glog_cyc[$];

    function automatic logic [31:0] seed_fn(input int k);
        return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // RAM: acks one cycle after a sampled strobe; may also emit stray acks when idle.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 256; k++) ram_mem[k] <= seed_fn(k);
        end else if (ram_en && ram_we && !noack_active) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        ram_ack   <= (ram_en && !noack_active) || (cyc == force_a) || (cyc == force_b) ||
                     (!ram_en && noise_en && !noack_active && ($urandom_range(3) == 0));
        ram_rdata <= ram_en ? ram_mem[ram_addr] : $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_grant(input bit to_d);
        txn_t t;
        bit   bad;
        if (to_d) begin
            t = dq.pop_front();
            d_wait = (dq.size() > 0) ? dq[0].gap : 0;
        end else begin
            t = iq.pop_front();
            i_wait = (iq.size() > 0) ? iq[0].gap : 0;
        end
        bad       = (t.addr[1:0] != 2'b00) || (t.addr[31:10] != 22'd0);
        last_d    = to_d;
        rp_d      = to_d;
        resp_pend = 1'b1;
        iss_ok    = !bad;
        iss_cyc   = cyc + 1;
        iss_word  = t.addr[9:2];
        iss_we    = t.we;
        iss_wdata = t.we ? t.wdata : 32'd0;
        if (bad) begin
            resp_cyc = cyc + 1; rerr = 1'b1; rdata_exp = '0;
        end else if (t.noack) begin
            resp_cyc = cyc + 2 + int'(TIMEOUT); rerr = 1'b1; rdata_exp = '0;
            noack_active = 1'b1;
        end else begin
            resp_cyc = cyc + 2; rerr = 1'b0;
            if (t.we) begin
                rdata_exp = '0;
                model_mem[t.addr[9:2]] = t.wdata;
            end else begin
                rdata_exp = model_mem[t.addr[9:2]];
            end
        end
        free_cyc = resp_cyc + 1;
    endtask

    task automatic eval();
        bit eg_i, eg_d, ev, een;
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (!rst && cyc >= free_cyc) begin
            if (i_req && d_req) begin
                if (last_d) eg_i = 1'b1; else eg_d = 1'b1;
            end else begin
                eg_i = i_req;
                eg_d = d_req;
            end
        end
        ev  = !rst && resp_pend && (cyc == resp_cyc);
        een = !rst && resp_pend && iss_ok && (cyc == iss_cyc);

        check("i_gnt", 32'(i_gnt), 32'(eg_i));
        check("d_gnt", 32'(d_gnt), 32'(eg_d));
        check("i_rvalid", 32'(i_rvalid), 32'(ev && !rp_d));
        check("d_rvalid", 32'(d_rvalid), 32'(ev && rp_d));
        check("ram_en", 32'(ram_en), 32'(een));
        check("ram_we", 32'(ram_we), 32'(een && iss_we));
        check("ram_addr", 32'(ram_addr), een ? 32'(iss_word) : 32'd0);
        check("ram_wdata", ram_wdata, een ? iss_wdata : 32'd0);
        if (ev && !rp_d) begin
            check("i_err", 32'(i_err), 32'(rerr));
            check("i_rdata", i_rdata, rdata_exp);
        end
        if (ev && rp_d) begin
            check("d_err", 32'(d_err), 32'(rerr));
            check("d_rdata", d_rdata, rdata_exp);
        end
        if (rst || (resp_pend && rp_d)) begin
            check("i_idle_rdata", i_rdata, 32'd0);
            check("i_idle_err", 32'(i_err), 32'd0);
        end
        if (rst || (resp_pend && !rp_d)) begin
            check("d_idle_rdata", d_rdata, 32'd0);
            check("d_idle_err", 32'(d_err), 32'd0);
        end

        if (ram_en) begin ram_en_cnt++; last_ram_addr = ram_addr; end
        if (i_gnt) begin gnt_cyc[0] = cyc; glog_port.push_back(1'b0); glog_cyc.push_back(cyc); end
        if (d_gnt) begin gnt_cyc[1] = cyc; glog_port.push_back(1'b1); glog_cyc.push_back(cyc); d_gnt_cnt++; end
        if (i_rvalid) begin rsp_cyc[0] = cyc; rsp_err[0] = i_err; rsp_data[0] = i_rdata; rsp_cnt++; end
        if (d_rvalid) begin rsp_cyc[1] = cyc; rsp_err[1] = d_err; rsp_data[1] = d_rdata; rsp_cnt++; end

        if (rst) begin
            resp_pend = 1'b0; last_d = 1'b0; free_cyc = cyc + 1; noack_active = 1'b0;
        end else begin
            if (ev) begin resp_pend = 1'b0; noack_active = 1'b0; end
            if (eg_i || eg_d) do_grant(eg_d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst = (rst_cnt > 0);
        if (rst_cnt > 0) rst_cnt--;
        if (iq.size() > 0 && i_wait == 0) begin
            i_req = 1'b1; i_addr = iq[0].addr;
        end else begin
            i_req = 1'b0; i_addr = $urandom;
            if (i_wait > 0) i_wait--;
        end
        if (dq.size() > 0 && d_wait == 0) begin
            d_req = 1'b1; d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
        end else begin
            d_req = 1'b0; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
            if (d_wait > 0) d_wait--;
        end
        @(negedge clk);
        eval();
        cyc++;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || resp_pend) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_bound", 32'(iq.size() + dq.size() + int'(resp_pend)), 32'd0);
        step();
    endtask

    function automatic txn_t mk(input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit noack);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.noack = noack; t.gap = 0;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit is_d);
        txn_t t;
        int   sel;
        sel     = $urandom_range(19);
        t.we    = is_d ? 1'($urandom_range(1)) : 1'b0;
        t.addr  = 32'($urandom_range(255)) << 2;
        t.wdata = $urandom;
        t.noack = (sel == 2);
        t.gap   = ($urandom_range(1) == 0) ? 0 : $urandom_range(3);
        if (sel == 0) t.addr[1:0] = 2'($urandom_range(3, 1));
        if (sel == 1) t.addr[31:10] = 22'($urandom_range(4194303, 1));
        if (t.noack) t.we = 1'b0;
        return t;
    endfunction

    initial begin
        int n0, r0, n;
        rst = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 256; k++) model_mem[k] = seed_fn(k);

        init_mem = 1'b1;
        rst_cnt  = 3;
        repeat (3) step();
        init_mem = 1'b0;
        check("reset_i_gnt", 32'(i_gnt), 32'd0);
        check("reset_ram_en", 32'(ram_en), 32'd0);

        // Write through data port, read back through fetch port.
        dq.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0));
        drain(50);
        iq.push_back(mk(1'b0, 32'h10, 32'h0, 1'b0));
        drain(50);
        check("dir_ram_addr", 32'(last_ram_addr), 32'd4);
        check("dir_i_rdata", rsp_data[0], 32'hDEAD_BEEF);
        check("dir_i_latency", 32'(rsp_cyc[0] - gnt_cyc[0]), 32'd2);

        // Both ports held from reset: D, I, D, I, three cycles apart.
        for (int k = 0; k < 2; k++) begin
            iq.push_back(mk(1'b0, 32'(k) * 32'd4, 32'h0, 1'b0));
            dq.push_back(mk(1'b0, 32'h100 + 32'(k) * 32'd4, 32'h0, 1'b0));
        end
        rst_cnt = 2;
        glog_port.delete();
        glog_cyc.delete();
        drain(100);
        check("rr_count", 32'(glog_port.size()), 32'd4);
        if (glog_port.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("rr_port", 32'(glog_port[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
                if (k > 0) check("rr_spacing", 32'(glog_cyc[k] - glog_cyc[k-1]), 32'd3);
            end
        end

        // Misaligned data read and out-of-range fetch: error after one cycle, no RAM access.
        n0 = ram_en_cnt;
        dq.push_back(mk(1'b0, 32'h6, 32'h0, 1'b0));
        drain(50);
        check("misalign_err", 32'(rsp_err[1]), 32'd1);
        check("misalign_latency", 32'(rsp_cyc[1] - gnt_cyc[1]), 32'd1);
        iq.push_back(mk(1'b0, 32'h400, 32'h0, 1'b0));
        drain(50);
        check("range_err", 32'(rsp_err[0]), 32'd1);
        check("range_latency", 32'(rsp_cyc[0] - gnt_cyc[0]), 32'd1);
        check("err_no_ram", 32'(ram_en_cnt - n0), 32'd0);

        // Suppressed ack: timeout error, then a normal access.
        dq.push_back(mk(1'b0, 32'h20, 32'h0, 1'b1));
        drain(50);
        check("timeout_err", 32'(rsp_err[1]), 32'd1);
        check("timeout_latency", 32'(rsp_cyc[1] - gnt_cyc[1]), 32'd2 + TIMEOUT);
        iq.push_back(mk(1'b0, 32'h20, 32'h0, 1'b0));
        drain(50);
        check("after_to_err", 32'(rsp_err[0]), 32'd0);
        check("after_to_rdata", rsp_data[0], seed_fn(8));

        // Reset while waiting; acks arriving during and after reset must be dropped.
        n0 = d_gnt_cnt;
        dq.push_back(mk(1'b0, 32'h30, 32'h0, 1'b1));
        n = 0;
        while (d_gnt_cnt == n0 && n < 20) begin step(); n++; end
        check("rst_mid_granted", 32'(d_gnt_cnt - n0), 32'd1);
        step();
        r0 = rsp_cnt;
        force_a = cyc;
        force_b = cyc + 1;
        rst_cnt = 1;
        repeat (3) step();
        check("rst_mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        iq.push_back(mk(1'b0, 32'h30, 32'h0, 1'b0));
        drain(50);
        check("rst_mid_next_rdata", rsp_data[0], seed_fn(12));
        check("rst_mid_next_latency", 32'(rsp_cyc[0] - gnt_cyc[0]), 32'd2);

        // Random traffic on both ports with stray acks.
        noise_en = 1'b1;
        for (int k = 0; k < 80; k++) begin
            iq.push_back(rand_txn(1'b0));
            dq.push_back(rand_txn(1'b1));
        end
        drain(20000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
